// File: rtl/minterm_sweep_pkg.sv
`default_nettype none
// ============================================================================
// minterm_sweep_pkg : shared types and constants for the minterm sweep checker
// Rev 1.0
// ============================================================================
package minterm_sweep_pkg;
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int          NUM_VEC      = 16;
   localparam int          IDX_W        = 4;
   localparam logic [15:0] DEF_EXP_MASK = 16'h48C6;
endpackage
`default_nettype wire

// File: rtl/sweep_vec_counter.sv
`default_nettype none
// ============================================================================
// sweep_vec_counter : vector index and settle-wait generation with sample strobes
// Rev 1.0
// ============================================================================
module sweep_vec_counter
   import minterm_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_sample,
   output logic             o_last_sample
);
   localparam logic [2:0]       c_SETTLE   = 3'(SETTLE);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VEC - 1);

   logic [IDX_W-1:0] r_idx;
   logic [2:0]       r_wcnt;
   logic             w_sample;

   assign w_sample      = i_run && (r_wcnt == c_SETTLE);
   assign o_sample      = w_sample;
   assign o_last_sample = w_sample && (r_idx == c_LAST_IDX);
   assign o_idx         = r_idx;

   // Index wraps 15 -> 0 naturally on the last sample, leaving the counter parked at 0.
   always_ff @(posedge clk) begin
      if (rst || !i_run) begin
         r_idx  <= '0;
         r_wcnt <= '0;
      end else if (w_sample) begin
         r_idx  <= r_idx + 1'b1;
         r_wcnt <= '0;
      end else begin
         r_wcnt <= r_wcnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/minterm_sweep_checker.sv
`default_nettype none
// ============================================================================
// minterm_sweep_checker : sweeps a/b/c/d over all minterms and checks f_in against EXP_MASK
// Rev 1.0
// ============================================================================
module minterm_sweep_checker
   import minterm_sweep_pkg::*;
#(
   parameter logic [15:0] EXP_MASK = DEF_EXP_MASK,
   parameter int          SETTLE   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        f_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [3:0]  first_err_idx,
   output logic [15:0] mismatch_map
);
   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [4:0]       r_err_count;
   logic [3:0]       r_first_err_idx;
   logic [15:0]      r_mismatch_map;

   logic [IDX_W-1:0] w_idx;
   logic             w_sample;
   logic             w_last_sample;
   logic             w_mismatch;

   sweep_vec_counter #(
      .SETTLE (SETTLE)
   ) u_vec_counter (
      .clk           (clk),
      .rst           (rst),
      .i_run         (r_state == RUN),
      .o_idx         (w_idx),
      .o_sample      (w_sample),
      .o_last_sample (w_last_sample)
   );

   assign w_mismatch = (f_in != EXP_MASK[w_idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_err_count     <= '0;
         r_first_err_idx <= '0;
         r_mismatch_map  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state         <= RUN;
                  r_busy          <= 1'b1;
                  r_pass          <= 1'b0;
                  r_err_count     <= '0;
                  r_first_err_idx <= '0;
                  r_mismatch_map  <= '0;
               end
            end
            RUN: begin
               if (w_sample && w_mismatch) begin
                  r_mismatch_map[w_idx] <= 1'b1;
                  r_err_count           <= r_err_count + 5'd1;
                  if (r_err_count == 5'd0)
                     r_first_err_idx <= w_idx;
               end
               // Pass must account for a mismatch on minterm 15 landing on this same edge.
               if (w_last_sample) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_count == 5'd0) && !w_mismatch;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign {a, b, c, d}   = w_idx;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_count;
   assign first_err_idx  = r_first_err_idx;
   assign mismatch_map   = r_mismatch_map;
endmodule
`default_nettype wire

// File: tb/tb_minterm_sweep_checker.sv
`default_nettype none
// ============================================================================
// tb_minterm_sweep_checker : directed bench for the minterm sweep checker
// Rev 1.0
// ============================================================================
module tb_minterm_sweep_checker;
   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start1 = 1'b0;
   logic        a1, b1, c1, d1, f1, busy1, done1, pass1;
   logic [4:0]  err1;
   logic [3:0]  first1;
   logic [15:0] map1;
   logic [1:0]  mode = 2'd0;

   logic        start0 = 1'b0;
   logic        a0, b0, c0, d0, f0, busy0, done0, pass0;
   logic [4:0]  err0;
   logic [3:0]  first0;
   logic [15:0] map0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Reference F = sum(1,2,6,7,11,14)
   function automatic logic fref(input logic [3:0] m);
      return (m == 4'd1) || (m == 4'd2) || (m == 4'd6) || (m == 4'd7) ||
             (m == 4'd11) || (m == 4'd14);
   endfunction

   always_comb begin
      case (mode)
         2'd0:    f1 = fref({a1, b1, c1, d1});
         2'd1:    f1 = 1'b0;
         2'd2:    f1 = ~fref({a1, b1, c1, d1});
         default: f1 = fref({a1, b1, c1, d1}) | ({a1, b1, c1, d1} == 4'd15);
      endcase
   end
   assign f0 = fref({a0, b0, c0, d0});

   minterm_sweep_checker #(.EXP_MASK(16'h48C6), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .first_err_idx(first1), .mismatch_map(map1)
   );

   minterm_sweep_checker #(.EXP_MASK(16'h48C6), .SETTLE(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
      .a(a0), .b(b0), .c(c0), .d(d0), .f_in(f0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .first_err_idx(first0), .mismatch_map(map0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One full SETTLE=1 sweep on dut1; optionally pokes start mid-sweep.
   task automatic sweep1(input string tag, input logic [4:0] e_err, input logic [15:0] e_map,
                         input logic [3:0] e_first, input logic e_pass, input bit poke);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk({tag, "_start"}, {busy1, done1, a1, b1, c1, d1}, {1'b1, 1'b0, 4'd0});
      for (int e = 1; e <= 32; e++) begin
         if (poke && (e == 7 || e == 20)) start1 = 1'b1;
         tick();
         start1 = 1'b0;
         if (e < 32)
            chk({tag, "_vec"}, {busy1, done1, a1, b1, c1, d1}, {1'b1, 1'b0, 4'(e / 2)});
      end
      chk({tag, "_done"}, {busy1, done1, a1, b1, c1, d1}, {1'b0, 1'b1, 4'd0});
      chk({tag, "_pass"}, pass1, e_pass);
      chk({tag, "_err"}, err1, e_err);
      chk({tag, "_map"}, map1, e_map);
      if (e_err != 5'd0) chk({tag, "_first"}, first1, e_first);
      tick();
      chk({tag, "_done_1cyc"}, {busy1, done1}, 2'b00);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outs", {busy1, done1, pass1, err1, first1, map1, a1, b1, c1, d1}, 32'd0);
      chk("reset_outs0", {busy0, done0, pass0, err0, first0, map0, a0, b0, c0, d0}, 32'd0);

      mode = 2'd0;
      sweep1("golden", 5'd0, 16'h0000, 4'd0, 1'b1, 1'b0);
      mode = 2'd1;
      sweep1("stuck0", 5'd6, 16'h48C6, 4'd1, 1'b0, 1'b0);
      mode = 2'd2;
      sweep1("invert", 5'd16, 16'hFFFF, 4'd0, 1'b0, 1'b0);
      mode = 2'd3;
      sweep1("last15", 5'd1, 16'h8000, 4'd15, 1'b0, 1'b0);
      tick();
      tick();
      chk("hold_results", {pass1, err1, first1, map1}, {1'b0, 5'd1, 4'd15, 16'h8000});

      // Reset mid-sweep at idx=5, with a stray start pulse earlier in the sweep.
      mode = 2'd0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         if (e == 3) start1 = 1'b1;
         tick();
         start1 = 1'b0;
      end
      chk("pre_rst_idx", {busy1, a1, b1, c1, d1}, {1'b1, 4'd5});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_outs", {busy1, done1, pass1, err1, first1, map1, a1, b1, c1, d1}, 32'd0);
      tick();
      tick();
      chk("post_rst_idle", {busy1, done1, a1, b1, c1, d1}, 6'd0);
      sweep1("restart", 5'd0, 16'h0000, 4'd0, 1'b1, 1'b1);
      tick();
      chk("no_restart", {busy1, a1, b1, c1, d1}, 5'd0);

      // SETTLE=0 build, start held high for back-to-back sweeps.
      start0 = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         chk("s0_start", {busy0, done0, pass0, err0, a0, b0, c0, d0}, {1'b1, 1'b0, 1'b0, 5'd0, 4'd0});
         for (int e = 1; e <= 16; e++) begin
            if (s == 1 && e == 1) start0 = 1'b0;
            tick();
            if (e < 16)
               chk("s0_vec", {busy0, done0, a0, b0, c0, d0}, {1'b1, 1'b0, 4'(e)});
         end
         chk("s0_done", {busy0, done0, pass0, err0, map0}, {1'b0, 1'b1, 1'b1, 5'd0, 16'h0000});
         tick();
      end
      chk("s0_idle", {busy0, done0}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
